doodle_motion: RTL and testbench

Motion generator that drives the doodle jump controller's kinematic inputs. It consumes the controller's one-hot state outputs (q_I, q_Up, q_Down, q_Done) and the player's left/right buttons. It produces the doodle position (object_x, object_y) and the jump progress counter (up_count) that the controller compares against JUMP_HEIGHT. It sits between the button debouncers and the jump controller, and its positions also feed the VGA renderer.

---
 rtl/doodle_motion_pkg.sv | 20 ++
 rtl/doodle_motion_tick_divider.sv | 27 ++
 rtl/doodle_motion.sv | 89 ++++++++
 tb/tb_doodle_motion.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/doodle_motion_pkg.sv
// doodle_motion_pkg: screen geometry, start position and the jump controller's one-hot states.
package doodle_motion_pkg;
    localparam int H_OFFSET      = 144;
    localparam int V_OFFSET      = 35;
    localparam int H_RES         = 630;
    localparam int V_RES         = 480;
    localparam int DOODLE_RADIUS = 13;
    localparam int DEF_START_X   = 406;
    localparam int DEF_START_Y   = 498 - DOODLE_RADIUS;
    localparam int DEF_X_MIN     = H_OFFSET + DOODLE_RADIUS;
    localparam int DEF_X_MAX     = H_OFFSET + H_RES - DOODLE_RADIUS;
    localparam int DEF_Y_MIN     = V_OFFSET + DOODLE_RADIUS;
    localparam int DEF_Y_FLOOR   = V_OFFSET + V_RES + 25;
    typedef enum logic [3:0] {
        ST_I    = 4'b0001,
        ST_UP   = 4'b0010,
        ST_DOWN = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;
endpackage

// File: rtl/doodle_motion_tick_divider.sv
// tick_divider: one-cycle move_tick every TICK_DIV enabled cycles; counter held at 0 when disabled.
module tick_divider #(
    parameter int TICK_DIV = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_enable,
    output logic o_move_tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] L_LAST = W'(TICK_DIV - 1);
    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nx;
    logic         r_tick;
    assign w_count_nx  = (!i_enable || r_count == L_LAST) ? '0 : r_count + W'(1);
    assign o_move_tick = r_tick;
    // Tick is registered from the counter's next value so it tracks count == TICK_DIV-1 exactly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_count_nx;
            r_tick  <= i_enable && w_count_nx == L_LAST;
        end
    end
endmodule

// File: rtl/doodle_motion.sv
// doodle_motion: doodle position and jump-progress generator driven by the jump controller state.
module doodle_motion
    import doodle_motion_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int STEP_X    = 2,
    parameter int RISE_STEP = 2,
    parameter int MAX_FALL  = 6,
    parameter int START_X   = DEF_START_X,
    parameter int START_Y   = DEF_START_Y,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_FLOOR   = 540
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       q_I,
    input  logic       q_Up,
    input  logic       q_Down,
    input  logic       q_Done,
    input  logic       BtnL,
    input  logic       BtnR,
    output logic [9:0] object_x,
    output logic [9:0] object_y,
    output logic [9:0] up_count,
    output logic       move_tick
);
    state_t      w_state;
    logic        w_is_up, w_is_down, w_is_i;
    logic [10:0] w_x_inc, w_x_dec, w_x_nx, w_y_rise, w_y_sum, w_y_fall, w_up_sum, w_up_nx;
    logic [9:0]  r_x, r_y, r_up;
    logic [2:0]  r_fall;

    assign w_state   = state_t'({q_Done, q_Down, q_Up, q_I});
    assign w_is_i    = w_state == ST_I;
    assign w_is_up   = w_state == ST_UP;
    assign w_is_down = w_state == ST_DOWN;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_enable    (w_is_up || w_is_down),
        .o_move_tick (move_tick)
    );

    // All arithmetic at 11 bits; bounds are compared before subtracting so nothing underflows.
    assign w_x_inc  = {1'b0, r_x} + 11'(STEP_X);
    assign w_x_dec  = ({1'b0, r_x} < 11'(X_MIN + STEP_X)) ? 11'(X_MAX) : {1'b0, r_x} - 11'(STEP_X);
    assign w_x_nx   = (BtnL == BtnR) ? {1'b0, r_x} : BtnL ? w_x_dec
                    : (w_x_inc > 11'(X_MAX)) ? 11'(X_MIN) : w_x_inc;
    assign w_y_rise = ({1'b0, r_y} < 11'(Y_MIN + RISE_STEP)) ? 11'(Y_MIN) : {1'b0, r_y} - 11'(RISE_STEP);
    assign w_y_sum  = {1'b0, r_y} + {8'd0, r_fall};
    assign w_y_fall = (w_y_sum > 11'(Y_FLOOR)) ? 11'(Y_FLOOR) : w_y_sum;
    assign w_up_sum = {1'b0, r_up} + 11'(RISE_STEP);
    assign w_up_nx  = (w_up_sum > 11'd1023) ? 11'd1023 : w_up_sum;

    assign object_x = r_x;
    assign object_y = r_y;
    assign up_count = r_up;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x    <= 10'(START_X);
            r_y    <= 10'(START_Y);
            r_up   <= '0;
            r_fall <= 3'd1;
        end else if (w_is_i) begin
            r_x    <= 10'(START_X);
            r_y    <= 10'(START_Y);
            r_up   <= '0;
            r_fall <= 3'd1;
        end else if (w_is_up) begin
            if (move_tick) begin
                r_x    <= w_x_nx[9:0];
                r_y    <= w_y_rise[9:0];
                r_up   <= w_up_nx[9:0];
                r_fall <= 3'd1;
            end
        end else if (w_is_down) begin
            r_up <= '0;
            if (move_tick) begin
                r_x    <= w_x_nx[9:0];
                r_y    <= w_y_fall[9:0];
                r_fall <= (r_fall >= 3'(MAX_FALL)) ? 3'(MAX_FALL) : r_fall + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_doodle_motion.sv
// tb_doodle_motion: directed scoreboard bench for doodle_motion with TICK_DIV = 4.
module tb_doodle_motion;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       q_I, q_Up, q_Down, q_Done, BtnL, BtnR;
    logic [9:0] object_x, object_y, up_count;
    logic       move_tick;

    localparam logic [3:0] S_I = 4'b0001, S_UP = 4'b0010, S_DN = 4'b0100, S_DONE = 4'b1000;

    typedef struct {int x; int y; int u; int t;} exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int mx, my, mu, mf, mc, mt;

    always #5 Clk = ~Clk;

    doodle_motion #(.TICK_DIV(4)) dut (
        .Clk(Clk), .Reset(Reset), .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
        .BtnL(BtnL), .BtnR(BtnR), .object_x(object_x), .object_y(object_y),
        .up_count(up_count), .move_tick(move_tick)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 406; my = 485; mu = 0; mf = 1; mc = 0; mt = 0;
        sb.delete();
    endtask

    // Drive one cycle, push the reference outcome, then pop and compare after the edge.
    task automatic cyc(input logic [3:0] st, input logic l, input logic r);
        exp_t e;
        bit tk, en;
        {q_Done, q_Down, q_Up, q_I} = st;
        BtnL = l;
        BtnR = r;
        tk = (mt == 1);
        en = (st == S_UP) || (st == S_DN);
        if (st == S_I) begin
            mx = 406; my = 485; mu = 0; mf = 1;
        end else if (st == S_UP && tk) begin
            mu = (mu + 2 > 1023) ? 1023 : mu + 2;
            my = (my - 2 < 48) ? 48 : my - 2;
            mf = 1;
        end else if (st == S_DN) begin
            mu = 0;
            if (tk) begin
                my = (my + mf > 540) ? 540 : my + mf;
                mf = (mf + 1 > 6) ? 6 : mf + 1;
            end
        end
        if (en && tk && l && !r) mx = (mx - 2 < 157) ? 761 : mx - 2;
        if (en && tk && r && !l) mx = (mx + 2 > 761) ? 157 : mx + 2;
        mc = en ? ((mc == 3) ? 0 : mc + 1) : 0;
        mt = (en && mc == 3) ? 1 : 0;
        e.x = mx; e.y = my; e.u = mu; e.t = mt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("x", int'(object_x), e.x);
        chk("y", int'(object_y), e.y);
        chk("up_count", int'(up_count), e.u);
        chk("move_tick", int'(move_tick), e.t);
    endtask

    initial begin
        int ticks, py;
        int steps[8] = '{1, 2, 3, 4, 5, 6, 6, 6};
        {q_Done, q_Down, q_Up, q_I} = S_I;
        BtnL = 1'b0;
        BtnR = 1'b0;
        #12;
        chk("reset_x", int'(object_x), 406);
        chk("reset_y", int'(object_y), 485);
        chk("reset_up", int'(up_count), 0);
        chk("reset_tick", int'(move_tick), 0);
        #10 Reset = 1'b0;
        @(posedge Clk);
        #1;
        model_reset();

        repeat (20) cyc(S_I, 1'b0, 1'b0);
        chk("idle_x", int'(object_x), 406);
        chk("idle_y", int'(object_y), 485);

        ticks = 0;
        repeat (40) begin
            cyc(S_UP, 1'b0, 1'b0);
            ticks += int'(move_tick);
        end
        chk("rise_ticks", ticks, 10);
        chk("rise_up", int'(up_count), 20);
        chk("rise_y", int'(object_y), 465);

        py = 465;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(S_DN, 1'b0, 1'b0);
                if (k == 0 && j == 0) chk("down_up0", int'(up_count), 0);
            end
            chk("fall_step", int'(object_y) - py, steps[k]);
            py = int'(object_y);
        end
        chk("fall_y", int'(object_y), 498);

        repeat (179 * 4) cyc(S_DN, 1'b0, 1'b1);
        chk("wrap_setup_x", int'(object_x), 159);
        repeat (4) cyc(S_DN, 1'b1, 1'b0);
        chk("left_157", int'(object_x), 157);
        repeat (4) cyc(S_DN, 1'b1, 1'b0);
        chk("left_wrap", int'(object_x), 761);
        repeat (4) cyc(S_DN, 1'b0, 1'b1);
        chk("right_wrap", int'(object_x), 157);
        repeat (8) cyc(S_DN, 1'b1, 1'b1);
        chk("both_hold", int'(object_x), 157);
        chk("floor_y", int'(object_y), 540);

        cyc(S_UP, 1'b0, 1'b0);
        chk("up_entry0", int'(up_count), 0);
        repeat (2079) cyc(S_UP, 1'b0, 1'b0);
        chk("ceil_y", int'(object_y), 48);
        chk("up_sat", int'(up_count), 1023);

        repeat (100) cyc(S_DONE, 1'b1, 1'b0);
        chk("done_x", int'(object_x), 157);
        chk("done_y", int'(object_y), 48);
        chk("done_up", int'(up_count), 1023);

        repeat (4) cyc(4'b0000, 1'b0, 1'b1);
        repeat (4) cyc(4'b0110, 1'b0, 1'b1);
        chk("illegal_x", int'(object_x), 157);
        chk("illegal_up", int'(up_count), 1023);

        repeat (3) cyc(S_UP, 1'b0, 1'b1);
        chk("pre_reset_tick", int'(move_tick), 1);
        #3 Reset = 1'b1;
        #1;
        chk("async_x", int'(object_x), 406);
        chk("async_y", int'(object_y), 485);
        chk("async_up", int'(up_count), 0);
        chk("async_tick", int'(move_tick), 0);
        {q_Done, q_Down, q_Up, q_I} = S_I;
        #10 Reset = 1'b0;
        @(posedge Clk);
        #1;
        model_reset();
        repeat (8) cyc(S_UP, 1'b0, 1'b0);
        chk("resume_y", int'(object_y), 481);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
